// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package if_prefetch_pkg;

  // Fetch FSM encodings, visible on the top-level debug port
  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_t;

  localparam logic        ENABLE    = 1'b1;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int          INST_W    = 32;

endpackage

// File: rtl/if_prefetch_queue.sv
// Synchronous FIFO holding {pc, inst} entries for the prefetch unit.
// Head data comes straight from storage, so it is registered.
module if_prefetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wdata,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; flush discards contents but keeps storage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch unit with prefetch queue. Issues pipelined memory beats,
// assembles them little-endian into 32-bit words and queues {pc, inst}.
// Handshakes: a memory beat transfers when mem_req_o & mem_gnt_i; once raised,
// mem_req_o/mem_addr_o stay put until granted (only branch/rst withdraw it).
// An instruction transfers to if_id when inst_valid_o & inst_ready_i.
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                MEM_BYTES   = 1,
  parameter int                QUEUE_DEPTH = 4,
  parameter int                MAX_OUT     = 2,
  parameter logic [ADDR_W-1:0] PC_RESET    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   branch_i,
  input  logic [ADDR_W-1:0]      branch_addr_i,
  input  logic                   stall_i,
  output logic                   mem_req_o,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [8*MEM_BYTES-1:0] mem_rdata_i,
  output logic                   inst_valid_o,
  output logic [31:0]            inst_o,
  output logic [ADDR_W-1:0]      pc_o,
  input  logic                   inst_ready_i,
  output logic [1:0]             dbg_state
);

  localparam int BEATS   = 4 / MEM_BYTES;
  localparam int BEAT_W  = 8 * MEM_BYTES;
  localparam int OUT_W   = $clog2(MAX_OUT + 1);
  localparam int CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam int ENTRY_W = ADDR_W + INST_W;

  if_state_t         state;
  if_state_t         state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] asm_pc;
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  drop_cnt;
  logic [OUT_W-1:0]  drop_next;
  logic [1:0]        rx_beat;
  logic [1:0]        tx_beat;
  logic [31:0]       asm_buf;
  logic [31:0]       asm_word;
  logic [CNT_W-1:0]  asm_insts;
  logic              req_hold;

  logic              fire;
  logic              accept;
  logic              last_beat;
  logic              push;
  logic              pop;
  logic              slot_ok;
  logic              issue_ok;

  logic [ENTRY_W-1:0] q_rdata;
  logic               q_full;
  logic               q_empty;
  logic [CNT_W-1:0]   q_count;

  assign fire      = mem_req_o && mem_gnt_i;
  assign accept    = mem_rvalid_i && (drop_cnt == '0) && !branch_i;
  assign last_beat = (rx_beat == 2'(BEATS - 1));
  assign push      = accept && last_beat;
  assign pop       = inst_valid_o && inst_ready_i && !branch_i;

  // Beats of an already-started instruction never need a new slot; only the
  // first beat of an instruction reserves one, otherwise a full queue could
  // strand a half-fetched instruction.
  assign slot_ok  = (tx_beat != 2'd0) ||
                    ((CNT_W+1)'(q_count) + (CNT_W+1)'(asm_insts) < (CNT_W+1)'(QUEUE_DEPTH));
  assign issue_ok = !stall_i && (out_cnt < OUT_W'(MAX_OUT)) && slot_ok;

  assign mem_req_o    = (state != IF_IDLE) && (req_hold || issue_ok);
  assign mem_addr_o   = mem_req_o ? fetch_pc : '0;
  assign inst_valid_o = !q_empty;
  assign inst_o       = q_rdata[INST_W-1:0];
  assign pc_o         = q_rdata[ENTRY_W-1:INST_W];
  assign dbg_state    = state;

  // Merge the arriving beat into the partial word at its byte lane
  always_comb begin
    asm_word = asm_buf;
    for (int b = 0; b < BEATS; b++) begin
      if (rx_beat == 2'(b)) asm_word[BEAT_W*b +: BEAT_W] = mem_rdata_i;
    end
  end

  // Stale-response counter: a branch marks everything still in flight as stale
  always_comb begin
    drop_next = drop_cnt;
    if (branch_i) drop_next = out_cnt + OUT_W'(fire) - OUT_W'(mem_rvalid_i);
    else if (mem_rvalid_i && (drop_cnt != '0)) drop_next = drop_cnt - OUT_W'(1);
  end

  // Next-state logic for the fetch FSM
  always_comb begin
    state_next = state;
    case (state)
      IF_IDLE:  state_next = IF_FETCH;
      IF_FETCH: if (branch_i && ((out_cnt - OUT_W'(mem_rvalid_i)) != '0)) state_next = IF_DRAIN;
      IF_DRAIN: if (drop_next == '0) state_next = IF_FETCH;
      default:  state_next = IF_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst == ENABLE) state <= IF_IDLE;
    else               state <= state_next;
  end

  // Fetch pointer, outstanding/drop counters and the beat assembler
  always_ff @(posedge clk) begin
    if (rst == ENABLE) begin
      fetch_pc  <= PC_RESET;
      asm_pc    <= PC_RESET;
      out_cnt   <= '0;
      drop_cnt  <= '0;
      rx_beat   <= 2'd0;
      tx_beat   <= 2'd0;
      asm_buf   <= ZERO_WORD;
      asm_insts <= '0;
      req_hold  <= 1'b0;
    end else begin
      out_cnt  <= out_cnt + OUT_W'(fire) - OUT_W'(mem_rvalid_i);
      drop_cnt <= drop_next;
      if (branch_i) begin
        fetch_pc  <= branch_addr_i;
        asm_pc    <= branch_addr_i;
        rx_beat   <= 2'd0;
        tx_beat   <= 2'd0;
        asm_buf   <= ZERO_WORD;
        asm_insts <= '0;
        req_hold  <= 1'b0;
      end else begin
        req_hold  <= mem_req_o && !mem_gnt_i;
        asm_insts <= asm_insts + CNT_W'(fire && (tx_beat == 2'd0)) - CNT_W'(push);
        if (fire) begin
          fetch_pc <= fetch_pc + ADDR_W'(MEM_BYTES);
          tx_beat  <= (tx_beat == 2'(BEATS - 1)) ? 2'd0 : tx_beat + 2'd1;
        end
        if (accept) begin
          if (last_beat) begin
            rx_beat <= 2'd0;
            asm_pc  <= asm_pc + ADDR_W'(4);
            asm_buf <= ZERO_WORD;
          end else begin
            rx_beat <= rx_beat + 2'd1;
            asm_buf <= asm_word;
          end
        end
      end
    end
  end

  if_prefetch_queue #(
    .WIDTH (ENTRY_W),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_i),
    .push  (push && (!q_full || pop)),
    .wdata ({asm_pc, asm_word}),
    .pop   (pop),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule
